// File: rtl/fifo_level_pkg.sv
// Shared constants and helpers for the fifo_level FIFO and its storage.
package fifo_level_pkg;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  function automatic int unsigned fifo_depth(input int unsigned depth_width);
    return 32'd1 << depth_width;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port; swappable for a vendor macro.
module fifo_mem
  import fifo_level_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] rd_data_d;

  // Storage array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      rd_data_d = mem_q[rd_addr_i];
    end
  end

  // Read register returns old contents on a same-address write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_level.sv
// Single-clock FIFO with registered fill level, almost-full/empty thresholds,
// protected overflow/underflow with sticky error flags, and optional FWFT read.
module fifo_level
  import fifo_level_pkg::*;
#(
  parameter int unsigned DEPTH_WIDTH   = 4,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned FWFT          = FIFO_MODE_STD,
  parameter int unsigned AFULL_THRESH  = fifo_depth(DEPTH_WIDTH) - 2,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  input  logic                   wr_en_i,
  output logic                   full_o,
  output logic                   almost_full_o,
  input  logic                   rd_en_i,
  output logic [DATA_WIDTH-1:0]  rd_data_o,
  output logic                   empty_o,
  output logic                   almost_empty_o,
  output logic [DEPTH_WIDTH:0]   level_o,
  output logic                   overflow_o,
  output logic                   underflow_o,
  input  logic                   clr_err_i
);

  localparam int unsigned DEPTH = fifo_depth(DEPTH_WIDTH);
  localparam int unsigned LVL_W = DEPTH_WIDTH + 1;

  if (DEPTH_WIDTH == 0 || DATA_WIDTH == 0 ||
      (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) ||
      AFULL_THRESH == 0 || AFULL_THRESH > DEPTH ||
      AEMPTY_THRESH > DEPTH - 1) begin : g_bad_param
    $error("fifo_level: illegal parameter combination");
  end

  logic [DEPTH_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   full_q, full_d;
  logic                   afull_q, afull_d;
  logic                   empty_q, empty_d;
  logic                   aempty_q, aempty_d;
  logic                   ovf_q, ovf_d;
  logic                   unf_q, unf_d;
  logic                   wr_acc;
  logic                   rd_acc;

  logic                   ram_rd_en;
  logic [DEPTH_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0]  ram_rd_data;

  // Acceptance, pointer/level update and flag derivation from the next level.
  always_comb begin
    wr_acc   = wr_en_i && !full_q;
    rd_acc   = rd_en_i && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + DEPTH_WIDTH'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + DEPTH_WIDTH'(1);
    end

    case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    full_d   = (level_d == LVL_W'(DEPTH));
    afull_d  = (level_d >= LVL_W'(AFULL_THRESH));
    empty_d  = (level_d == '0);
    aempty_d = (level_d <= LVL_W'(AEMPTY_THRESH));

    // A new error event outranks a same-cycle clear.
    if (clr_err_i) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (wr_en_i && full_q) begin
      ovf_d = 1'b1;
    end
    if (rd_en_i && empty_q) begin
      unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      empty_q  <= 1'b1;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      empty_q  <= empty_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .ADDR_WIDTH (DEPTH_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_acc),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_data_i),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (ram_rd_addr),
    .rd_data_o (ram_rd_data)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    logic                  byp_q, byp_d;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;

    // The RAM continuously prefetches the next head; a word that becomes head in
    // the same cycle it is written is served from the bypass register instead.
    always_comb begin
      ram_rd_en   = (level_d != '0);
      ram_rd_addr = rd_ptr_d;
      byp_d       = byp_q;
      byp_data_d  = byp_data_q;
      if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
        byp_d      = 1'b1;
        byp_data_d = wr_data_i;
      end else if (ram_rd_en) begin
        byp_d = 1'b0;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        byp_q      <= 1'b0;
        byp_data_q <= '0;
      end else begin
        byp_q      <= byp_d;
        byp_data_q <= byp_data_d;
      end
    end

    assign rd_data_o = byp_q ? byp_data_q : ram_rd_data;
  end else begin : g_std
    assign ram_rd_en   = rd_acc;
    assign ram_rd_addr = rd_ptr_q;
    assign rd_data_o   = ram_rd_data;
  end

  assign level_o        = level_q;
  assign full_o         = full_q;
  assign almost_full_o  = afull_q;
  assign empty_o        = empty_q;
  assign almost_empty_o = aempty_q;
  assign overflow_o     = ovf_q;
  assign underflow_o    = unf_q;

endmodule

// File: tb/tb_fifo_level.sv
// Self-checking bench: one standard-read and one FWFT instance against a queue model.
module tb_fifo_level;

  localparam int unsigned DW    = 2;
  localparam int unsigned XW    = 8;
  localparam int unsigned DEPTH = 4;

  logic clk;

  logic          s_rst, s_wr, s_rd, s_clr;
  logic [XW-1:0] s_wd, s_rdata;
  logic          s_full, s_afull, s_empty, s_aempty, s_ovf, s_unf;
  logic [DW:0]   s_level;

  logic          f_rst, f_wr, f_rd, f_clr;
  logic [XW-1:0] f_wd, f_rdata;
  logic          f_full, f_afull, f_empty, f_aempty, f_ovf, f_unf;
  logic [DW:0]   f_level;

  int n_assert = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  logic [XW-1:0] sq[$];
  logic [XW-1:0] fq[$];
  logic          s_ovf_m, s_unf_m, f_ovf_m, f_unf_m;
  logic [XW-1:0] s_rd_m;
  bit            f_fresh;

  fifo_level #(
    .DEPTH_WIDTH(DW), .DATA_WIDTH(XW), .FWFT(0), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) u_std (
    .clk(clk), .rst(s_rst), .wr_data_i(s_wd), .wr_en_i(s_wr), .full_o(s_full),
    .almost_full_o(s_afull), .rd_en_i(s_rd), .rd_data_o(s_rdata), .empty_o(s_empty),
    .almost_empty_o(s_aempty), .level_o(s_level), .overflow_o(s_ovf),
    .underflow_o(s_unf), .clr_err_i(s_clr)
  );

  fifo_level #(
    .DEPTH_WIDTH(DW), .DATA_WIDTH(XW), .FWFT(1), .AFULL_THRESH(3), .AEMPTY_THRESH(1)
  ) u_fwft (
    .clk(clk), .rst(f_rst), .wr_data_i(f_wd), .wr_en_i(f_wr), .full_o(f_full),
    .almost_full_o(f_afull), .rd_en_i(f_rd), .rd_data_o(f_rdata), .empty_o(f_empty),
    .almost_empty_o(f_aempty), .level_o(f_level), .overflow_o(f_ovf),
    .underflow_o(f_unf), .clr_err_i(f_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain word queue plus sticky error bits.
  always @(posedge clk) begin
    bit m_full, m_empty;
    if (s_rst) begin
      sq.delete();
      s_ovf_m = 1'b0;
      s_unf_m = 1'b0;
      s_rd_m  = '0;
    end else begin
      m_full  = (sq.size() == DEPTH);
      m_empty = (sq.size() == 0);
      if (s_clr) begin s_ovf_m = 1'b0; s_unf_m = 1'b0; end
      if (s_wr && m_full)  s_ovf_m = 1'b1;
      if (s_rd && m_empty) s_unf_m = 1'b1;
      if (s_rd && !m_empty) s_rd_m = sq.pop_front();
      if (s_wr && !m_full) sq.push_back(s_wd);
    end
    if (f_rst) begin
      fq.delete();
      f_ovf_m = 1'b0;
      f_unf_m = 1'b0;
      f_fresh = 1'b1;
    end else begin
      m_full  = (fq.size() == DEPTH);
      m_empty = (fq.size() == 0);
      if (f_clr) begin f_ovf_m = 1'b0; f_unf_m = 1'b0; end
      if (f_wr && m_full)  f_ovf_m = 1'b1;
      if (f_rd && m_empty) f_unf_m = 1'b1;
      if (f_rd && !m_empty) void'(fq.pop_front());
      if (f_wr && !m_full) begin
        fq.push_back(f_wd);
        f_fresh = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (started) begin
      chk("s_level",  32'(s_level),  32'(sq.size()));
      chk("s_full",   32'(s_full),   32'(sq.size() == DEPTH));
      chk("s_afull",  32'(s_afull),  32'(sq.size() >= 3));
      chk("s_empty",  32'(s_empty),  32'(sq.size() == 0));
      chk("s_aempty", 32'(s_aempty), 32'(sq.size() <= 1));
      chk("s_ovf",    32'(s_ovf),    32'(s_ovf_m));
      chk("s_unf",    32'(s_unf),    32'(s_unf_m));
      chk("s_rdata",  32'(s_rdata),  32'(s_rd_m));
      chk("f_level",  32'(f_level),  32'(fq.size()));
      chk("f_full",   32'(f_full),   32'(fq.size() == DEPTH));
      chk("f_afull",  32'(f_afull),  32'(fq.size() >= 3));
      chk("f_empty",  32'(f_empty),  32'(fq.size() == 0));
      chk("f_aempty", 32'(f_aempty), 32'(fq.size() <= 1));
      chk("f_ovf",    32'(f_ovf),    32'(f_ovf_m));
      chk("f_unf",    32'(f_unf),    32'(f_unf_m));
      if (fq.size() > 0) chk("f_head", 32'(f_rdata), 32'(fq[0]));
      else if (f_fresh)  chk("f_rst_rdata", 32'(f_rdata), 32'h0);
    end
  end

  task automatic s_cyc(input logic w, input logic [XW-1:0] d, input logic r, input logic c);
    s_wr = w; s_wd = d; s_rd = r; s_clr = c;
    @(negedge clk);
    s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0;
  endtask

  task automatic f_cyc(input logic w, input logic [XW-1:0] d, input logic r, input logic c);
    f_wr = w; f_wd = d; f_rd = r; f_clr = c;
    @(negedge clk);
    f_wr = 1'b0; f_rd = 1'b0; f_clr = 1'b0;
  endtask

  initial begin
    s_rst = 1'b1; s_wr = 1'b0; s_rd = 1'b0; s_clr = 1'b0; s_wd = '0;
    f_rst = 1'b1; f_wr = 1'b0; f_rd = 1'b0; f_clr = 1'b0; f_wd = '0;
    @(negedge clk);
    started = 1'b1;
    s_rst = 1'b0;
    f_rst = 1'b0;

    chk("rst_level",  32'(s_level),  32'd0);
    chk("rst_empty",  32'(s_empty),  32'd1);
    chk("rst_aempty", 32'(s_aempty), 32'd1);
    chk("rst_full",   32'(s_full),   32'd0);
    chk("rst_rdata",  32'(s_rdata),  32'h0);

    // Standard mode: fill, overflow handling, simultaneous at full, drain.
    s_cyc(1'b1, 8'h11, 1'b0, 1'b0); chk("fill1_level", 32'(s_level), 32'd1);
    chk("fill1_aempty", 32'(s_aempty), 32'd1);
    s_cyc(1'b1, 8'h22, 1'b0, 1'b0); chk("fill2_aempty", 32'(s_aempty), 32'd0);
    s_cyc(1'b1, 8'h33, 1'b0, 1'b0); chk("fill3_afull", 32'(s_afull), 32'd1);
    chk("fill3_full", 32'(s_full), 32'd0);
    s_cyc(1'b1, 8'h44, 1'b0, 1'b0); chk("fill4_full", 32'(s_full), 32'd1);
    chk("fill4_level", 32'(s_level), 32'd4);
    s_cyc(1'b1, 8'h55, 1'b0, 1'b0); chk("ovf_set", 32'(s_ovf), 32'd1);
    chk("ovf_level", 32'(s_level), 32'd4);
    s_cyc(1'b0, 8'h00, 1'b0, 1'b0); chk("ovf_sticky", 32'(s_ovf), 32'd1);
    s_cyc(1'b0, 8'h00, 1'b0, 1'b1); chk("ovf_clr", 32'(s_ovf), 32'd0);
    s_cyc(1'b1, 8'h55, 1'b0, 1'b1); chk("ovf_set_wins", 32'(s_ovf), 32'd1);
    s_cyc(1'b0, 8'h00, 1'b0, 1'b1);
    s_cyc(1'b1, 8'h66, 1'b1, 1'b0); chk("simfull_rdata", 32'(s_rdata), 32'h11);
    chk("simfull_level", 32'(s_level), 32'd3);
    chk("simfull_ovf", 32'(s_ovf), 32'd1);
    s_cyc(1'b0, 8'h00, 1'b1, 1'b0); chk("rd2", 32'(s_rdata), 32'h22);
    s_cyc(1'b0, 8'h00, 1'b1, 1'b0); chk("rd3", 32'(s_rdata), 32'h33);
    s_cyc(1'b0, 8'h00, 1'b1, 1'b0); chk("rd4", 32'(s_rdata), 32'h44);
    chk("drain_empty", 32'(s_empty), 32'd1);
    s_cyc(1'b0, 8'h00, 1'b0, 1'b0); chk("rdata_hold", 32'(s_rdata), 32'h44);

    // Simultaneous read and write at empty.
    s_cyc(1'b1, 8'hA5, 1'b1, 1'b0); chk("simempty_unf", 32'(s_unf), 32'd1);
    chk("simempty_level", 32'(s_level), 32'd1);
    s_cyc(1'b0, 8'h00, 1'b1, 1'b0); chk("simempty_rd", 32'(s_rdata), 32'hA5);

    // Reset mid-operation.
    s_cyc(1'b1, 8'h01, 1'b0, 1'b0);
    s_cyc(1'b1, 8'h02, 1'b0, 1'b0);
    s_cyc(1'b1, 8'h03, 1'b0, 1'b0); chk("pre_rst_level", 32'(s_level), 32'd3);
    s_rst = 1'b1;
    @(negedge clk);
    s_rst = 1'b0;
    chk("midrst_level",  32'(s_level),  32'd0);
    chk("midrst_empty",  32'(s_empty),  32'd1);
    chk("midrst_aempty", 32'(s_aempty), 32'd1);
    chk("midrst_unf",    32'(s_unf),    32'd0);
    chk("midrst_ovf",    32'(s_ovf),    32'd0);
    chk("midrst_rdata",  32'(s_rdata),  32'h0);

    // FWFT: fall-through, then wrap through the bypass and RAM paths.
    chk("f_rst_empty", 32'(f_empty), 32'd1);
    f_cyc(1'b1, 8'h77, 1'b0, 1'b0); chk("fwft_empty", 32'(f_empty), 32'd0);
    chk("fwft_rdata", 32'(f_rdata), 32'h77);
    f_cyc(1'b0, 8'h00, 1'b1, 1'b0); chk("fwft_pop_empty", 32'(f_empty), 32'd1);
    f_cyc(1'b1, 8'h80, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      f_cyc(1'b1, 8'(8'h81 + i), 1'b1, 1'b0);
      chk("fwft_wrap", 32'(f_rdata), 32'(8'h81 + i));
    end
    f_cyc(1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) f_cyc(1'b1, 8'(8'hC1 + i), 1'b0, 1'b0);
    chk("fwft_full", 32'(f_full), 32'd1);
    chk("fwft_full_head", 32'(f_rdata), 32'hC1);
    f_cyc(1'b0, 8'h00, 1'b1, 1'b0); chk("fwft_pop_c2", 32'(f_rdata), 32'hC2);
    for (int i = 0; i < 6; i++) f_cyc(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0);
    chk("fwft_steady_head", 32'(f_rdata), 32'hD3);
    chk("fwft_steady_level", 32'(f_level), 32'd3);
    f_cyc(1'b0, 8'h00, 1'b1, 1'b0); chk("fwft_d4", 32'(f_rdata), 32'hD4);
    f_cyc(1'b0, 8'h00, 1'b1, 1'b0); chk("fwft_d5", 32'(f_rdata), 32'hD5);
    f_cyc(1'b0, 8'h00, 1'b1, 1'b0);
    f_cyc(1'b0, 8'h00, 1'b1, 1'b0); chk("fwft_unf", 32'(f_unf), 32'd1);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
